// File: rtl/riscv_pkg.sv
// Core-wide constants and types shared by the register file and writeback path.
package riscv_pkg;

   localparam int unsigned XLEN     = 32;
   localparam int unsigned REG_AW   = 5;
   localparam int unsigned NUM_REGS = 32;

   typedef logic [REG_AW-1:0] reg_addr_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant over a request vector.
// The search starts one past the last source that transferred.
module rr_arbiter #(
   parameter int unsigned N    = 3,
   parameter int unsigned IdxW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    req,
   input  logic            xfer,
   output logic [N-1:0]    gnt,
   output logic [IdxW-1:0] gnt_idx
);

   logic [IdxW-1:0] last_q;
   int unsigned     cand;
   logic            found;

   // Rotating priority search starting just after the last granted source
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      cand    = 0;
      found   = 1'b0;
      for (int unsigned k = 1; k <= N; k++) begin
         cand = (32'(last_q) + k) % N;
         if (!found && req[cand]) begin
            found     = 1'b1;
            gnt_idx   = IdxW'(cand);
            gnt[cand] = 1'b1;
         end
      end
   end

   // Pointer moves only on an actual transfer; reset gives source 0 first priority
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= IdxW'(N - 1);
      end else if (xfer) begin
         last_q <= gnt_idx;
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the register file write port, plus the per-register
// busy scoreboard used by issue. The output stage drives wr/wr_data directly.
module regfile_wb_arbiter #(
   parameter int unsigned N_SRC  = 3,
   parameter int unsigned XLEN   = riscv_pkg::XLEN,
   parameter int unsigned REG_AW = riscv_pkg::REG_AW
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_SRC-1:0]        src_valid,
   output logic [N_SRC-1:0]        src_ready,
   input  logic [N_SRC*REG_AW-1:0] src_rd,
   input  logic [N_SRC*XLEN-1:0]   src_data,
   output logic [REG_AW-1:0]       wr,
   output logic [XLEN-1:0]         wr_data,
   input  logic                    iss_set,
   input  logic [REG_AW-1:0]       iss_rd,
   input  logic [REG_AW-1:0]       q_rs1,
   input  logic [REG_AW-1:0]       q_rs2,
   output logic                    q_rs1_busy,
   output logic                    q_rs2_busy
);

   import riscv_pkg::*;

   localparam int unsigned IdxW    = $clog2(N_SRC);
   localparam int unsigned NumRegs = 1 << REG_AW;

   logic [N_SRC-1:0]   gnt;
   logic [IdxW-1:0]    gnt_idx;
   logic               xfer;
   logic [REG_AW-1:0]  sel_rd;
   logic [XLEN-1:0]    sel_data;
   logic [REG_AW-1:0]  wr_q;
   logic [XLEN-1:0]    wr_data_q;
   logic [NumRegs-1:1] busy_q;
   logic [NumRegs-1:1] busy_d;
   logic [NumRegs-1:0] busy_vec;

   rr_arbiter #(
      .N    (N_SRC),
      .IdxW (IdxW)
   ) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (src_valid),
      .xfer    (xfer),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   // The arbiter only grants requesting sources, so a grant is a transfer
   assign src_ready = gnt;
   assign xfer      = |(src_valid & gnt);
   assign sel_rd    = src_rd[32'(gnt_idx) * REG_AW +: REG_AW];
   assign sel_data  = src_data[32'(gnt_idx) * XLEN +: XLEN];

   // Output stage: capture the winner; idle cycles write x0 and hold the data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q      <= '0;
         wr_data_q <= '0;
      end else if (xfer) begin
         wr_q      <= sel_rd;
         wr_data_q <= sel_data;
      end else begin
         wr_q      <= '0;
      end
   end

   assign wr      = wr_q;
   assign wr_data = wr_data_q;

   // Scoreboard next state: clear on commit, then set, so set wins a collision
   always_comb begin
      busy_d = busy_q;
      if (wr_q != '0) begin
         busy_d[wr_q] = 1'b0;
      end
      if (iss_set && (iss_rd != '0)) begin
         busy_d[iss_rd] = 1'b1;
      end
   end

   // Scoreboard state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   // x0 is never busy
   assign busy_vec   = {busy_q, 1'b0};
   assign q_rs1_busy = busy_vec[q_rs1];
   assign q_rs2_busy = busy_vec[q_rs2];

   // Issue must stall on WAW; a register committing on this edge counts as free
   a_no_waw_set: assert property (@(posedge clk) disable iff (!rst_n)
      (iss_set && (iss_rd != '0) && (wr_q != iss_rd)) |-> !busy_vec[iss_rd]);

   a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(src_ready));

   a_ready_only_valid: assert property (@(posedge clk) disable iff (!rst_n)
      (src_ready & ~src_valid) == '0);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: cycle table, directed corner sequences and a
// randomized run against a behavioural model of arbitration and scoreboard.
module tb_regfile_wb_arbiter;

   localparam int N  = 3;
   localparam int AW = 5;
   localparam int DW = 32;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [N-1:0]      src_valid;
   logic [N-1:0]      src_ready;
   logic [N*AW-1:0]   src_rd;
   logic [N*DW-1:0]   src_data;
   logic [AW-1:0]     wr;
   logic [DW-1:0]     wr_data;
   logic              iss_set;
   logic [AW-1:0]     iss_rd;
   logic [AW-1:0]     q_rs1;
   logic [AW-1:0]     q_rs2;
   logic              q_rs1_busy;
   logic              q_rs2_busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   regfile_wb_arbiter #(
      .N_SRC  (N),
      .XLEN   (DW),
      .REG_AW (AW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .src_valid  (src_valid),
      .src_ready  (src_ready),
      .src_rd     (src_rd),
      .src_data   (src_data),
      .wr         (wr),
      .wr_data    (wr_data),
      .iss_set    (iss_set),
      .iss_rd     (iss_rd),
      .q_rs1      (q_rs1),
      .q_rs2      (q_rs2),
      .q_rs1_busy (q_rs1_busy),
      .q_rs2_busy (q_rs2_busy)
   );

   typedef struct {
      bit          rst;
      logic [2:0]  valid;
      logic [4:0]  rd0, rd1, rd2;
      logic [31:0] d1;
      logic        iss;
      logic [4:0]  irD;
      logic [4:0]  q1;
      logic [2:0]  exp_ready;
      logic [4:0]  exp_wr;
      logic [31:0] exp_wdata;
      logic        exp_busy;
   } vec_t;

   localparam logic [31:0] D0  = 32'hA0A0_0000;
   localparam logic [31:0] D2  = 32'hA2A2_0002;
   localparam logic [31:0] D1R = 32'hA1A1_0001;

   vec_t tab[$];

   function automatic vec_t mk(bit r, logic [2:0] v, logic [4:0] a0, logic [4:0] a1,
                               logic [4:0] a2, logic [31:0] d1, logic is, logic [4:0] ir,
                               logic [4:0] q, logic [2:0] er, logic [4:0] ew,
                               logic [31:0] ed, logic eb);
      vec_t t;
      t.rst = r; t.valid = v; t.rd0 = a0; t.rd1 = a1; t.rd2 = a2; t.d1 = d1;
      t.iss = is; t.irD = ir; t.q1 = q; t.exp_ready = er; t.exp_wr = ew;
      t.exp_wdata = ed; t.exp_busy = eb;
      return t;
   endfunction

   task automatic check(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      src_valid = '0; src_rd = '0; src_data = '0;
      iss_set = 1'b0; iss_rd = '0; q_rs1 = '0; q_rs2 = '0;
   endtask

   // Leaves the bench at posedge+1 of the first cycle after reset
   task automatic do_reset();
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_src(int i, logic v, logic [4:0] rd, logic [31:0] d);
      src_valid[i]          = v;
      src_rd[i*AW +: AW]    = rd;
      src_data[i*DW +: DW]  = d;
   endtask

   // Behavioural model state for the random phase
   int           m_last;
   bit           m_busy[32];
   logic [4:0]   m_wr;
   logic [31:0]  m_wd;
   bit           pv[N];
   logic [4:0]   prd[N];
   logic [31:0]  pdat[N];
   int           waitc[N];

   initial begin
      #1_000_000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b1;
      idle_inputs();

      // Single-source writeback (cycle 0 follows reset)
      tab.push_back(mk(1, 3'b000, 0, 0, 0, 0,             0, 0, 5, 3'b000, 0, 0,             0));
      tab.push_back(mk(0, 3'b000, 0, 0, 0, 0,             1, 5, 5, 3'b000, 0, 0,             0));
      tab.push_back(mk(0, 3'b000, 0, 0, 0, 0,             0, 0, 5, 3'b000, 0, 0,             1));
      tab.push_back(mk(0, 3'b010, 0, 5, 0, 32'hDEADBEEF, 0, 0, 5, 3'b010, 0, 0,             1));
      tab.push_back(mk(0, 3'b000, 0, 0, 0, 0,             0, 0, 5, 3'b000, 5, 32'hDEADBEEF, 1));
      tab.push_back(mk(0, 3'b000, 0, 0, 0, 0,             0, 0, 5, 3'b000, 0, 32'hDEADBEEF, 0));
      // Round-robin fairness, then a lone requester granted every cycle
      tab.push_back(mk(1, 3'b111, 1, 2, 3, D1R, 0, 0, 0, 3'b001, 0, 0,   0));
      tab.push_back(mk(0, 3'b111, 1, 2, 3, D1R, 0, 0, 0, 3'b010, 1, D0,  0));
      tab.push_back(mk(0, 3'b111, 1, 2, 3, D1R, 0, 0, 0, 3'b100, 2, D1R, 0));
      tab.push_back(mk(0, 3'b111, 1, 2, 3, D1R, 0, 0, 0, 3'b001, 3, D2,  0));
      tab.push_back(mk(0, 3'b111, 1, 2, 3, D1R, 0, 0, 0, 3'b010, 1, D0,  0));
      tab.push_back(mk(0, 3'b000, 1, 2, 3, D1R, 0, 0, 0, 3'b000, 2, D1R, 0));
      tab.push_back(mk(0, 3'b100, 1, 2, 3, D1R, 0, 0, 0, 3'b100, 0, D1R, 0));
      tab.push_back(mk(0, 3'b100, 1, 2, 3, D1R, 0, 0, 0, 3'b100, 3, D2,  0));
      tab.push_back(mk(0, 3'b000, 1, 2, 3, D1R, 0, 0, 0, 3'b000, 3, D2,  0));
      tab.push_back(mk(0, 3'b000, 1, 2, 3, D1R, 0, 0, 0, 3'b000, 0, D2,  0));

      for (int i = 0; i < tab.size(); i++) begin
         if (tab[i].rst) do_reset();
         src_valid = tab[i].valid;
         src_rd    = {tab[i].rd2, tab[i].rd1, tab[i].rd0};
         src_data  = {D2, tab[i].d1, D0};
         iss_set   = tab[i].iss;
         iss_rd    = tab[i].irD;
         q_rs1     = tab[i].q1;
         @(negedge clk);
         check($sformatf("tab%0d_ready", i), src_ready, tab[i].exp_ready);
         check($sformatf("tab%0d_wr", i), wr, tab[i].exp_wr);
         check($sformatf("tab%0d_wdata", i), wr_data, tab[i].exp_wdata);
         check($sformatf("tab%0d_busy", i), q_rs1_busy, tab[i].exp_busy);
         tick();
      end

      // Set/clear collision on rd 7: set wins
      do_reset();
      iss_set = 1'b1; iss_rd = 7; q_rs1 = 7;
      @(negedge clk); check("coll_busy_before", q_rs1_busy, 0);
      tick(); iss_set = 1'b0;
      set_src(0, 1'b1, 7, 32'h77);
      @(negedge clk); check("coll_ready", src_ready, 3'b001); check("coll_busy_set", q_rs1_busy, 1);
      tick(); set_src(0, 1'b0, 0, 0);
      iss_set = 1'b1; iss_rd = 7;
      @(negedge clk); check("coll_wr", wr, 7);
      tick(); iss_set = 1'b0;
      @(negedge clk); check("coll_set_wins", q_rs1_busy, 1); check("coll_wr_idle", wr, 0);
      tick(); set_src(0, 1'b1, 7, 32'h78);
      @(negedge clk); check("coll_ready2", src_ready, 3'b001);
      tick(); set_src(0, 1'b0, 0, 0);
      @(negedge clk); check("coll_wr2", wr, 7); check("coll_busy_still", q_rs1_busy, 1);
      tick();
      @(negedge clk); check("coll_cleared", q_rs1_busy, 0);
      tick();

      // x0 writeback is accepted but discarded; scoreboard untouched
      iss_set = 1'b1; iss_rd = 4; q_rs2 = 4;
      tick(); iss_set = 1'b0;
      set_src(0, 1'b1, 0, 32'h1234);
      @(negedge clk); check("x0_ready", src_ready, 3'b001); check("x0_busy4", q_rs2_busy, 1);
      tick(); set_src(0, 1'b0, 0, 0);
      @(negedge clk); check("x0_wr", wr, 0); check("x0_busy4_kept", q_rs2_busy, 1);
      q_rs1 = 0;
      @(posedge clk); #1;
      @(negedge clk); check("x0_never_busy", q_rs1_busy, 0);
      tick();

      // Reset mid-operation with a write in the output stage and one in flight
      do_reset();
      iss_set = 1'b1; iss_rd = 9;
      tick(); iss_set = 1'b0;
      set_src(1, 1'b1, 9, 32'h99);
      tick();
      set_src(1, 1'b1, 10, 32'h1010);
      q_rs1 = 9;
      @(negedge clk);
      check("rst_pre_wr", wr, 9); check("rst_pre_busy", q_rs1_busy, 1);
      check("rst_pre_ready", src_ready, 3'b010);
      rst_n = 1'b0;
      #1;
      check("rst_wr", wr, 0); check("rst_wdata", wr_data, 0); check("rst_busy9", q_rs1_busy, 0);
      @(posedge clk); #1;
      check("rst_drop_inflight", wr, 0);
      rst_n = 1'b1;
      set_src(1, 1'b1, 1, 32'h11); set_src(2, 1'b1, 2, 32'h22);
      @(negedge clk); check("rst_first_grant", src_ready, 3'b010);
      tick();
      @(negedge clk); check("rst_first_wr", wr, 1); check("rst_second_grant", src_ready, 3'b100);
      tick();

      // Randomized run against the behavioural model
      do_reset();
      m_last = N - 1; m_wr = 0; m_wd = 0;
      for (int r = 0; r < 32; r++) m_busy[r] = 0;
      for (int i = 0; i < N; i++) begin pv[i] = 0; waitc[i] = 0; end
      for (int c = 0; c < 3000; c++) begin
         int g;
         int cand_r;
         logic [N-1:0] exp_ready;
         for (int i = 0; i < N; i++) begin
            if (!pv[i]) begin
               pv[i]   = ($urandom_range(0, 99) < 55);
               prd[i]  = 5'($urandom_range(0, 31));
               pdat[i] = $urandom;
               waitc[i] = 0;
            end
            set_src(i, pv[i], prd[i], pdat[i]);
         end
         cand_r = $urandom_range(0, 31);
         iss_rd = 5'(cand_r);
         iss_set = ($urandom_range(0, 99) < 40) &&
                   (cand_r == 0 || !m_busy[cand_r] || m_wr == 5'(cand_r));
         q_rs1 = 5'($urandom_range(0, 31));
         q_rs2 = 5'($urandom_range(0, 31));

         g = -1;
         for (int k = 1; k <= N; k++) begin
            if (g < 0 && pv[(m_last + k) % N]) g = (m_last + k) % N;
         end
         exp_ready = '0;
         if (g >= 0) exp_ready[g] = 1'b1;

         @(negedge clk);
         check("rnd_ready", src_ready, exp_ready);
         check("rnd_wr", wr, m_wr);
         check("rnd_wdata", wr_data, m_wd);
         check("rnd_q1", q_rs1_busy, m_busy[q_rs1]);
         check("rnd_q2", q_rs2_busy, m_busy[q_rs2]);
         if (g >= 0) check("rnd_starvation_bound", (waitc[g] < N), 1);

         if (m_wr != 0) m_busy[m_wr] = 0;
         if (iss_set && iss_rd != 0) m_busy[iss_rd] = 1;
         if (g >= 0) begin
            m_wr = prd[g]; m_wd = pdat[g]; m_last = g; pv[g] = 0;
         end else begin
            m_wr = 0;
         end
         for (int i = 0; i < N; i++) if (pv[i]) waitc[i]++;
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
